// File: rtl/irq_ctrl.sv
// irq_ctrl: collects NUM_IRQ peripheral lines into one CPU interrupt behind a valid/ready register port.
// Bus response is registered one cycle after acceptance; lowest index has fixed priority on CLAIM.
module irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               irq_out,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [7:0]         mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata
);
  localparam int PAD = 32 - NUM_IRQ;
  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_EN    = 2'd1;
  localparam logic [1:0] A_MODE  = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;

  logic [NUM_IRQ-1:0] r_pend, r_en, r_mode, r_prev, r_ack;
  logic               r_irq_out, r_ready;
  logic [31:0]        r_rdata;

  logic               w_acc, w_wr, w_rd, w_inblk;
  logic               w_sel_pend, w_sel_en, w_sel_mode, w_sel_claim;
  logic [NUM_IRQ-1:0] w_pe, w_claim_oh, w_w1c, w_clr, w_set, w_pend_nxt;
  logic               w_claim_hit, w_do_claim;
  logic [4:0]         w_claim_idx;
  logic [31:0]        w_bmask, w_pend32, w_en32, w_mode32, w_en_nxt, w_mode_nxt, w_rdata_nxt;
  logic               w_unused;

  // A request seen while ready is high belongs to the transaction just completed.
  assign w_acc   = mem_valid & ~r_ready;
  assign w_wr    = w_acc & (|mem_wstrb);
  assign w_rd    = w_acc & ~(|mem_wstrb);
  assign w_inblk = (mem_addr[7:4] == 4'h0);

  assign w_sel_pend  = w_inblk & (mem_addr[3:2] == A_PEND);
  assign w_sel_en    = w_inblk & (mem_addr[3:2] == A_EN);
  assign w_sel_mode  = w_inblk & (mem_addr[3:2] == A_MODE);
  assign w_sel_claim = w_inblk & (mem_addr[3:2] == A_CLAIM);

  assign w_pend32 = {{PAD{1'b0}}, r_pend};
  assign w_en32   = {{PAD{1'b0}}, r_en};
  assign w_mode32 = {{PAD{1'b0}}, r_mode};
  assign w_bmask  = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_en_nxt   = (w_en32 & ~w_bmask) | (mem_wdata & w_bmask);
  assign w_mode_nxt = (w_mode32 & ~w_bmask) | (mem_wdata & w_bmask);

  assign w_pe = r_pend & r_en;

  always_comb begin
    w_claim_hit = 1'b0;
    w_claim_idx = 5'd0;
    w_claim_oh  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pe[i]) begin
        w_claim_hit   = 1'b1;
        w_claim_idx   = 5'(i);
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
      end
    end
  end

  assign w_do_claim = w_rd & w_sel_claim & w_claim_hit;
  assign w_w1c      = (w_wr & w_sel_pend) ? mem_wdata[NUM_IRQ-1:0] : '0;
  assign w_clr      = w_w1c | (w_do_claim ? w_claim_oh : '0);
  assign w_set      = irq_in & ~r_prev;
  // Edge sources: a new edge beats a same-cycle clear. Level sources just track the line.
  assign w_pend_nxt = (r_mode & (w_set | (r_pend & ~w_clr))) | (~r_mode & irq_in);

  always_comb begin
    w_rdata_nxt = 32'h0;
    if (w_rd && w_inblk) begin
      case (mem_addr[3:2])
        A_PEND:  w_rdata_nxt = w_pend32;
        A_EN:    w_rdata_nxt = w_en32;
        A_MODE:  w_rdata_nxt = w_mode32;
        default: w_rdata_nxt = w_claim_hit ? {1'b1, 26'h0, w_claim_idx} : 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= '0;
      r_en      <= '0;
      r_mode    <= '0;
      r_prev    <= '0;
      r_ack     <= '0;
      r_irq_out <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_prev    <= irq_in;
      r_pend    <= w_pend_nxt;
      r_ack     <= w_clr;
      r_irq_out <= |w_pe;
      r_ready   <= w_acc;
      r_rdata   <= w_rdata_nxt;
      if (w_wr && w_sel_en)   r_en   <= w_en_nxt[NUM_IRQ-1:0];
      if (w_wr && w_sel_mode) r_mode <= w_mode_nxt[NUM_IRQ-1:0];
    end
  end

  assign irq_ack   = r_ack;
  assign irq_out   = r_irq_out;
  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

  assign w_unused = ^{mem_addr[1:0], w_en_nxt[31:NUM_IRQ], w_mode_nxt[31:NUM_IRQ]};
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: vector table, directed corner sequences, then random traffic against a reference model.
module tb_irq_ctrl;
  localparam int N = 8;
  localparam bit [31:0] VMASK = (32'd1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in, irq_ack;
  logic          irq_out, mem_valid, mem_ready;
  logic [7:0]    mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  irq_ctrl #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_ack(irq_ack), .irq_out(irq_out),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: register file and pending bits updated from the documented rules.
  bit [31:0] m_pend, m_en, m_mode, m_prev, m_ack, m_rdata;
  bit        m_irq, m_ready;

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] d, bit [3:0] s);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & VMASK;
  endfunction

  always @(posedge clk) begin : model
    bit [31:0] in_v, clr, rdv, np, nen, nmode, pe;
    bit acc;
    int idx;
    in_v = 32'(irq_in);
    if (rst) begin
      m_pend = 0; m_en = 0; m_mode = 0; m_prev = 0; m_ack = 0; m_rdata = 0;
      m_irq = 0; m_ready = 0;
    end else begin
      acc = mem_valid && !m_ready;
      clr = 0; rdv = 0; np = 0; nen = m_en; nmode = m_mode;
      pe = m_pend & m_en;
      if (acc && mem_addr[7:4] == 4'h0) begin
        case (mem_addr[3:2])
          2'd0: if (mem_wstrb != 0) clr = mem_wdata & VMASK; else rdv = m_pend;
          2'd1: if (mem_wstrb != 0) nen = merge(m_en, mem_wdata, mem_wstrb); else rdv = m_en;
          2'd2: if (mem_wstrb != 0) nmode = merge(m_mode, mem_wdata, mem_wstrb); else rdv = m_mode;
          default: if (mem_wstrb == 0 && pe != 0) begin
            idx = 0;
            while (!pe[idx]) idx++;
            rdv = 32'h8000_0000 | 32'(idx);
            clr = 32'd1 << idx;
          end
        endcase
      end
      for (int i = 0; i < N; i++)
        np[i] = m_mode[i] ? ((in_v[i] && !m_prev[i]) || (m_pend[i] && !clr[i])) : in_v[i];
      m_irq = (pe != 0);
      m_pend = np; m_en = nen; m_mode = nmode; m_prev = in_v;
      m_ack = clr; m_ready = acc; m_rdata = rdv;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("mdl_irq_out", 32'(irq_out), 32'(m_irq));
      check("mdl_irq_ack", 32'(irq_ack), m_ack);
      check("mdl_mem_ready", 32'(mem_ready), 32'(m_ready));
      check("mdl_mem_rdata", mem_rdata, m_rdata);
    end
  end

  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic [N-1:0] ack, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      cyc = i + 1;
      if (mem_ready) got = 1'b1;
    end
    rd = mem_rdata;
    ack = irq_ack;
    mem_valid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL bus_timeout: no mem_ready within 8 cycles, addr 0x%0h", a);
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic [7:0]  exp_ack;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];
  logic [7:0] addr_pool[7];

  initial begin
    logic [31:0] rd;
    logic [N-1:0] ack;
    int cyc;
    int sel;
    vt[0]  = '{8'h00, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[1]  = '{8'h04, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[2]  = '{8'h08, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[3]  = '{8'h0C, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[4]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0,  8'h00};
    vt[5]  = '{8'h04, 32'h0,         4'h0, 32'hFF, 8'h00};
    vt[6]  = '{8'h04, 32'h0,         4'h1, 32'h0,  8'h00};
    vt[7]  = '{8'h04, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[8]  = '{8'h08, 32'hA5,        4'h1, 32'h0,  8'h00};
    vt[9]  = '{8'h08, 32'h0,         4'h0, 32'hA5, 8'h00};
    vt[10] = '{8'h08, 32'h0,         4'hE, 32'h0,  8'h00};
    vt[11] = '{8'h09, 32'h0,         4'h0, 32'hA5, 8'h00};
    vt[12] = '{8'h08, 32'h0,         4'hF, 32'h0,  8'h00};
    vt[13] = '{8'h44, 32'hFFFF_FFFF, 4'hF, 32'h0,  8'h00};
    vt[14] = '{8'h04, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[15] = '{8'h10, 32'h0,         4'h0, 32'h0,  8'h00};
    vt[16] = '{8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0,  8'h00};
    vt[17] = '{8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,  8'hFF};
    vt[18] = '{8'h00, 32'h0,         4'h0, 32'h0,  8'h00};
    addr_pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h0C, 8'h10, 8'hC4};

    rst = 1'b1; irq_in = '0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_irq_out", 32'(irq_out), 32'h0);
    check("rst_irq_ack", 32'(irq_ack), 32'h0);
    check("rst_mem_ready", 32'(mem_ready), 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    chk_on = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus(vt[i].addr, vt[i].wdata, vt[i].wstrb, rd, ack, cyc);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].exp_ack));
      if (i == 0) check("first_ready_latency", cyc, 1);
    end

    // Edge source 0: pulse, two-cycle latency to irq_out, then claim.
    bus(8'h08, 32'h01, 4'hF, rd, ack, cyc);
    bus(8'h04, 32'h01, 4'hF, rd, ack, cyc);
    @(negedge clk); irq_in = 8'h01;
    @(posedge clk); #1; check("edge_irq_out_c1", 32'(irq_out), 32'h0);
    @(negedge clk); irq_in = 8'h00;
    @(posedge clk); #1; check("edge_irq_out_c2", 32'(irq_out), 32'h1);
    bus(8'h0C, 32'h0, 4'h0, rd, ack, cyc);
    check("claim0_rdata", rd, 32'h8000_0000);
    check("claim0_ack", 32'(ack), 32'h01);
    @(posedge clk); #1;
    check("claim0_irq_out_after", 32'(irq_out), 32'h0);
    check("claim0_ack_one_cycle", 32'(irq_ack), 32'h0);
    check("claim0_ready_one_cycle", 32'(mem_ready), 32'h0);

    // Level source 3 held high: W1C acks but pending returns.
    bus(8'h08, 32'h00, 4'hF, rd, ack, cyc);
    bus(8'h04, 32'h08, 4'hF, rd, ack, cyc);
    @(negedge clk); irq_in = 8'h08;
    repeat (3) @(posedge clk); #1;
    check("lvl_irq_out_on", 32'(irq_out), 32'h1);
    bus(8'h00, 32'h08, 4'hF, rd, ack, cyc);
    check("lvl_w1c_ack", 32'(ack), 32'h08);
    bus(8'h00, 32'h0, 4'h0, rd, ack, cyc);
    check("lvl_pending_reasserts", rd, 32'h08);
    check("lvl_irq_out_stays", 32'(irq_out), 32'h1);
    @(negedge clk); irq_in = 8'h00;
    bus(8'h00, 32'h08, 4'hF, rd, ack, cyc);
    check("lvl_w1c2_ack", 32'(ack), 32'h08);
    repeat (2) @(posedge clk); #1;
    check("lvl_irq_out_falls", 32'(irq_out), 32'h0);

    // Edge sources 2 and 5: priority order on successive claims.
    bus(8'h08, 32'h24, 4'hF, rd, ack, cyc);
    bus(8'h04, 32'h24, 4'hF, rd, ack, cyc);
    @(negedge clk); irq_in = 8'h24;
    @(negedge clk); irq_in = 8'h00;
    repeat (2) @(posedge clk);
    bus(8'h0C, 32'h0, 4'h0, rd, ack, cyc);
    check("prio_claim_a", rd, 32'h8000_0002); check("prio_ack_a", 32'(ack), 32'h04);
    bus(8'h0C, 32'h0, 4'h0, rd, ack, cyc);
    check("prio_claim_b", rd, 32'h8000_0005); check("prio_ack_b", 32'(ack), 32'h20);
    bus(8'h0C, 32'h0, 4'h0, rd, ack, cyc);
    check("prio_claim_none", rd, 32'h0); check("prio_ack_none", 32'(ack), 32'h00);

    // Edge source 1: rising edge coincides with W1C of the same bit.
    bus(8'h08, 32'h02, 4'hF, rd, ack, cyc);
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 8'h00; mem_wdata = 32'h02; mem_wstrb = 4'hF; irq_in = 8'h02;
    @(posedge clk); #1;
    check("coincide_ready", 32'(mem_ready), 32'h1);
    check("coincide_ack", 32'(irq_ack), 32'h02);
    mem_valid = 1'b0;
    bus(8'h00, 32'h0, 4'h0, rd, ack, cyc);
    check("coincide_set_wins", rd, 32'h02);
    bus(8'h00, 32'h02, 4'hF, rd, ack, cyc);
    bus(8'h00, 32'h0, 4'h0, rd, ack, cyc);
    check("held_high_no_reset", rd, 32'h00);

    // Masked pending source 4, then enable and byte-strobe behaviour.
    @(negedge clk); irq_in = 8'h00;
    bus(8'h08, 32'h10, 4'hF, rd, ack, cyc);
    bus(8'h04, 32'h00, 4'hF, rd, ack, cyc);
    @(negedge clk); irq_in = 8'h10;
    @(negedge clk); irq_in = 8'h00;
    repeat (2) @(posedge clk);
    bus(8'h00, 32'h0, 4'h0, rd, ack, cyc);
    check("mask_pending_kept", rd, 32'h10);
    check("mask_irq_out_low", 32'(irq_out), 32'h0);
    bus(8'h04, 32'h10, 4'hF, rd, ack, cyc);
    check("en_irq_out_at_ready", 32'(irq_out), 32'h0);
    @(posedge clk); #1;
    check("en_irq_out_next", 32'(irq_out), 32'h1);
    bus(8'h04, 32'h0000_FFFF, 4'h2, rd, ack, cyc);
    bus(8'h04, 32'h0, 4'h0, rd, ack, cyc);
    check("en_strb_byte1_only", rd, 32'h10);

    // Reset during an accepted-cycle request aborts it.
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 8'h0C; mem_wdata = 32'h0; mem_wstrb = 4'h0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_ready", 32'(mem_ready), 32'h0);
    check("rst_abort_ack", 32'(irq_ack), 32'h0);
    @(negedge clk); rst = 1'b0; mem_valid = 1'b0;
    bus(8'h04, 32'h0, 4'h0, rd, ack, cyc);
    check("rst_enable_cleared", rd, 32'h0);

    // Random traffic; the model checker compares every cycle.
    for (int k = 0; k < 400; k++) begin
      irq_in = N'($urandom);
      sel = $urandom_range(0, 6);
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'($urandom_range(0, 1)); mem_addr = 8'h0C; mem_wstrb = 4'h0;
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0;
      end else begin
        bus(addr_pool[sel], $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            rd, ack, cyc);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that aggregates up to NUM_IRQ peripheral interrupt lines (timer_irq, UART, GPIO, ...) into one CPU interrupt.
- Sits directly downstream of timer_irq: consumes its irq output and drives its irq_clear through a per-source acknowledge pulse.
- The CPU reaches it through the SoC's simple valid/ready memory bus. Software enables sources, selects edge or level mode per source, and claims the highest-priority pending source.

Parameters:
NUM_IRQ, 8, number of interrupt sources; legal range 1..31.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
irq_in  in  NUM_IRQ  raw interrupt lines from peripherals, already synchronous to clk
irq_ack  out  NUM_IRQ  one-cycle clear pulse per source; wire to peripheral irq_clear
irq_out  out  1  interrupt request to CPU
mem_valid  in  1  bus request; already qualified by the SoC address decode for this block
mem_ready  out  1  one-cycle transaction-complete pulse
mem_addr  in  8  byte offset within block
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; all zero means read
mem_rdata  out  32  read data, valid while mem_ready=1

Behaviour:
- Register map. Bits at or above NUM_IRQ read 0 and ignore writes.
  - 0x00 PENDING: read returns pending[]. Write is write-1-to-clear, and each written 1 also pulses irq_ack for that bit.
  - 0x04 ENABLE: read/write with byte strobes honoured. Reset value 0.
  - 0x08 MODE: read/write with byte strobes honoured. Bit=1 selects edge mode, bit=0 selects level mode. Reset value 0.
  - 0x0C CLAIM: read-only.
    - If any (pending & enable) bit is set, returns {bit31=1, bits[4:0]=lowest set index}. Side effect: clears that pending bit and pulses irq_ack[index].
    - Otherwise returns 0 and has no side effect.
    - Writes to CLAIM are ignored.
  - Any other offset (mem_addr[7:4]≠0 or mem_addr[1:0] ignored/word-aligned) reads 0 and ignores writes. mem_ready still pulses.
- Bus timing:
  - mem_valid is sampled at cycle T; mem_ready=1 and mem_rdata are driven at T+1, registered. mem_ready=0 at T+2.
  - The master holds mem_valid until it sees ready. The block ignores mem_valid during the cycle ready is high, so there is no double transaction.
  - Read and write side effects happen exactly once, at the T→T+1 edge.
  - mem_rdata=0 whenever mem_ready=0.
- Edge mode:
  - irq_prev is registered each cycle. A rising edge (irq_in & ~irq_prev) sets pending.
  - If set and clear (W1C or CLAIM) coincide in the same cycle, set wins.
  - An input held high does not re-set pending after a clear.
- Level mode:
  - pending[i] follows irq_in[i] with 1-cycle registration.
  - W1C and CLAIM still pulse irq_ack, but pending re-asserts next cycle if the line is still high.
- irq_out is registered: irq_out = |(pending & enable), i.e. 1 cycle after pending/enable update.
  - Enable=0 masks the source but does not clear pending.
- irq_ack:
  - Registered and asserted for exactly 1 cycle, coincident with mem_ready.
  - Multiple bits may pulse together on a W1C of several bits.
- Latency: edge on irq_in at cycle 0 → pending set at 1 → irq_out at 2.
- Reset: pending, enable, mode, irq_prev, irq_ack, irq_out, mem_ready and mem_rdata are all 0.
  - A reset mid-transaction aborts it: no ready pulse and no side effect.
  - irq_prev resets to 0, so a line already high after reset registers as an edge in edge mode.
- Priority is fixed: lowest index wins.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C → all read 0; irq_out=0; irq_ack=0.
- NUM_IRQ=8, MODE=0x01, ENABLE=0x01. Pulse irq_in[0] for 1 cycle → irq_out=1 two cycles later. Read CLAIM → 0x80000000, irq_ack[0] pulse of 1 cycle, irq_out=0 on the following cycle.
- Hold irq_in[3] high in level mode with ENABLE=0x08. Write PENDING=0x08 → irq_ack[3] pulses, pending[3] re-reads 1, irq_out stays 1. Drop irq_in[3], then W1C → irq_out falls.
- Edge sources 2 and 5 both pending, ENABLE=0x24. CLAIM → 0x80000002, then CLAIM → 0x80000005, then CLAIM → 0x00000000 with no ack pulse.
- Edge source 1: rising edge lands in the same cycle as a W1C of bit 1 → pending[1] remains 1.
- ENABLE=0 with pending=0x10 → irq_out=0. Write ENABLE=0x10 → irq_out=1 one cycle after mem_ready. Write ENABLE with wstrb=0b0010 → only bits[15:8] change.
